// File: rtl/seq_mul_div.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Produces one product or quotient bit per clock behind a start/busy/done handshake.
module seq_mul_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] doutHi,
    output logic [WIDTH-1:0] doutLo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;

    stateT              state;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;
    logic [CW-1:0]      count;
    logic               opDiv;
    logic               negQ;
    logic               negR;
    logic               divByZero;

    logic               signA;
    logic               signB;
    logic [WIDTH-1:0]   absA;
    logic [WIDTH-1:0]   absB;
    logic [WIDTH:0]     divTrial;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] accNext;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign busy = (state != IDLE);

    // acc holds {remainder, dividend/quotient} for divides and {partial sum, multiplier} for multiplies;
    // operand holds the divisor or the multiplicand, always as a magnitude.
    always_comb begin
        signA    = !mdOp[0] && din1[WIDTH-1];
        signB    = !mdOp[0] && din2[WIDTH-1];
        absA     = signA ? -din1 : din1;
        absB     = signB ? -din2 : din2;
        divTrial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, operand};
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        accNext  = acc;
        if (opDiv) begin
            if (!divTrial[WIDTH]) begin
                accNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                accNext = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            accNext = {mulSum, acc[WIDTH-1:1]};
        end else begin
            accNext = {1'b0, acc[2*WIDTH-1:1]};
        end
        product   = negQ ? -acc : acc;
        quotient  = divByZero ? {WIDTH{1'b1}} : (negQ ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
        remainder = negR ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state     <= IDLE;
            acc       <= '0;
            operand   <= '0;
            count     <= '0;
            opDiv     <= 1'b0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            divByZero <= 1'b0;
            done      <= 1'b0;
            divZero   <= 1'b0;
            doutHi    <= '0;
            doutLo    <= '0;
        end else begin
            done    <= 1'b0;
            divZero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        case (mdOp)
                            3'b100: begin
                                doutHi <= din1;
                                done   <= 1'b1;
                            end
                            3'b101: begin
                                doutLo <= din1;
                                done   <= 1'b1;
                            end
                            3'b000, 3'b001, 3'b010, 3'b011: begin
                                opDiv     <= !mdOp[1];
                                acc       <= {{WIDTH{1'b0}}, mdOp[1] ? absB : absA};
                                operand   <= mdOp[1] ? absA : absB;
                                negQ      <= signA ^ signB;
                                negR      <= signA;
                                divByZero <= !mdOp[1] && (din2 == '0);
                                count     <= CW'(WIDTH);
                                state     <= CALC;
                            end
                            default: ;
                        endcase
                    end
                end
                CALC: begin
                    if (cancel) begin
                        state <= IDLE;
                    end else begin
                        acc   <= accNext;
                        count <= count - CW'(1);
                        if (count == CW'(1)) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!cancel) begin
                        done <= 1'b1;
                        if (opDiv) begin
                            doutHi  <= remainder;
                            doutLo  <= quotient;
                            divZero <= divByZero;
                        end else begin
                            doutHi <= product[2*WIDTH-1:WIDTH];
                            doutLo <= product[WIDTH-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div: fixed vectors, handshake sequences and
// random operations checked against a plain-arithmetic reference model.
module tb_seq_mul_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstN;
    logic         start;
    logic         cancel;
    logic [2:0]   mdOp;
    logic [W-1:0] din1;
    logic [W-1:0] din2;
    logic         busy;
    logic         done;
    logic         divZero;
    logic [W-1:0] doutHi;
    logic [W-1:0] doutLo;

    int           testsRun    = 0;
    int           testsFailed = 0;
    logic [W-1:0] expHi = '0;
    logic [W-1:0] expLo = '0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        logic         hasDone;
    } resT;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } vecT;

    vecT vecs[12];

    seq_mul_div #(.WIDTH(W)) dut (
        .clk(clk), .rstN(rstN), .start(start), .mdOp(mdOp), .din1(din1), .din2(din2),
        .cancel(cancel), .busy(busy), .done(done), .divZero(divZero),
        .doutHi(doutHi), .doutLo(doutLo)
    );

    always #5 clk = ~clk;

    // Reference: what HI/LO/divZero must become, given the registers before the op.
    function automatic resT model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] hi, input logic [W-1:0] lo);
        resT                 r;
        logic signed [W-1:0]   sa;
        logic signed [W-1:0]   sb;
        logic signed [2*W-1:0] wa;
        logic signed [2*W-1:0] wb;
        logic [2*W-1:0]        p;
        logic [W-1:0]          minNeg;
        sa = a;
        sb = b;
        minNeg = {1'b1, {(W-1){1'b0}}};
        r.hi = hi;
        r.lo = lo;
        r.dz = 1'b0;
        r.hasDone = 1'b1;
        case (op)
            3'd0, 3'd1: begin
                if (b == '0) begin
                    r.lo = '1;
                    r.hi = a;
                    r.dz = 1'b1;
                end else if (op == 3'd0 && a == minNeg && b == '1) begin
                    r.lo = a;
                    r.hi = '0;
                end else if (op == 3'd0) begin
                    r.lo = sa / sb;
                    r.hi = sa % sb;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            3'd2: begin
                wa = sa;
                wb = sb;
                p = wa * wb;
                {r.hi, r.lo} = p;
            end
            3'd3: begin
                p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                {r.hi, r.lo} = p;
            end
            3'd4: r.hi = a;
            3'd5: r.lo = a;
            default: r.hasDone = 1'b0;
        endcase
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] required);
        testsRun++;
        if (actual !== required) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, required);
        end
    endtask

    // Issues one start and returns the cycle (1 = first after acceptance) in which done rose, or 0.
    task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output int lat, output int busyCnt);
        @(negedge clk);
        start = 1'b1;
        mdOp  = op;
        din1  = a;
        din2  = b;
        @(negedge clk);
        start   = 1'b0;
        din1    = $urandom;
        din2    = $urandom;
        lat     = 1;
        busyCnt = 0;
        while (!done && lat < W + 6) begin
            if (busy) busyCnt++;
            @(negedge clk);
            lat++;
        end
        if (!done) lat = 0;
    endtask

    task automatic runAndCheck(input string name, input logic [2:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input resT exp);
        int lat;
        int busyCnt;
        int expLat;
        applyStimulus(op, a, b, lat, busyCnt);
        expLat = !exp.hasDone ? 0 : (op[2] ? 1 : W + 2);
        checkOutput({name, ".latency"}, W'(lat), W'(expLat));
        checkOutput({name, ".busyCycles"}, W'(busyCnt), W'(op[2] ? 0 : W + 1));
        checkOutput({name, ".hi"}, doutHi, exp.hi);
        checkOutput({name, ".lo"}, doutLo, exp.lo);
        checkOutput({name, ".divZero"}, W'(divZero), W'(exp.dz));
        expHi = exp.hi;
        expLo = exp.lo;
    endtask

    initial begin
        resT          r;
        int           lat;
        logic         sawDone;
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;

        vecs[0]  = '{3'd2, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
        vecs[1]  = '{3'd3, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0};
        vecs[2]  = '{3'd0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{3'd1, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
        vecs[4]  = '{3'd1, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{3'd0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[6]  = '{3'd0, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
        vecs[7]  = '{3'd0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[8]  = '{3'd2, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[9]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[10] = '{3'd0, 32'h80000000, 32'h00000001, 32'h00000000, 32'h80000000, 1'b0};
        vecs[11] = '{3'd1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 1'b0};

        rstN = 1'b0; start = 1'b0; cancel = 1'b0; mdOp = '0; din1 = '0; din2 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.busy", W'(busy), '0);
        checkOutput("reset.done", W'(done), '0);
        checkOutput("reset.hi", doutHi, '0);
        checkOutput("reset.lo", doutLo, '0);
        rstN = 1'b1;

        // Reset in the middle of a multiply must clear everything.
        runAndCheck("mthiPre", 3'd4, 32'hCAFEF00D, '0, model(3'd4, 32'hCAFEF00D, '0, expHi, expLo));
        @(negedge clk);
        start = 1'b1; mdOp = 3'd2; din1 = 32'd3; din2 = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("midReset.busy", W'(busy), '0);
        checkOutput("midReset.hi", doutHi, '0);
        checkOutput("midReset.lo", doutLo, '0);
        expHi = '0;
        expLo = '0;
        runAndCheck("mthi", 3'd4, 32'h12345678, '0, '{32'h12345678, 32'h0, 1'b0, 1'b1});

        for (int i = 0; i < 12; i++) begin
            runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                        '{vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b1});
        end

        // start held high through busy with a different request must not disturb the op in flight.
        @(negedge clk);
        start = 1'b1; mdOp = 3'd2; din1 = 32'hFFFFFFFE; din2 = 32'd3;
        @(negedge clk);
        mdOp = 3'd4; din1 = 32'hDEADBEEF;
        lat = 1;
        while (!done && lat < W + 6) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("heldStart.latency", W'(lat), W'(W + 2));
        checkOutput("heldStart.hi", doutHi, 32'hFFFFFFFF);
        checkOutput("heldStart.lo", doutLo, 32'hFFFFFFFA);
        @(negedge clk);
        start = 1'b0;
        checkOutput("heldStart.mthiDone", W'(done), W'(1));
        checkOutput("heldStart.mthiHi", doutHi, 32'hDEADBEEF);
        checkOutput("heldStart.mthiLo", doutLo, 32'hFFFFFFFA);

        // Back-to-back: a start in the done cycle is accepted.
        runAndCheck("b2bFirst", 3'd3, 32'hFFFFFFFE, 32'd3, '{32'h2, 32'hFFFFFFFA, 1'b0, 1'b1});
        start = 1'b1; mdOp = 3'd1; din1 = 32'd7; din2 = 32'd2;
        @(negedge clk);
        start = 1'b0;
        checkOutput("b2b.donePulse", W'(done), '0);
        lat = 1;
        while (!done && lat < W + 6) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("b2b.latency", W'(lat), W'(W + 2));
        checkOutput("b2b.hi", doutHi, 32'd1);
        checkOutput("b2b.lo", doutLo, 32'd3);

        // Cancel in cycle 10 of a divide: no done, HI/LO keep their values.
        runAndCheck("preHi", 3'd4, 32'h0BADCAFE, '0, '{32'h0BADCAFE, 32'd3, 1'b0, 1'b1});
        runAndCheck("preLo", 3'd5, 32'h600DF00D, '0, '{32'h0BADCAFE, 32'h600DF00D, 1'b0, 1'b1});
        @(negedge clk);
        start = 1'b1; mdOp = 3'd0; din1 = 32'd100; din2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        sawDone = 1'b0;
        repeat (W + 4) begin
            sawDone |= done;
            @(negedge clk);
        end
        checkOutput("cancel.noDone", W'(sawDone), '0);
        checkOutput("cancel.busy", W'(busy), '0);
        checkOutput("cancel.hi", doutHi, 32'h0BADCAFE);
        checkOutput("cancel.lo", doutLo, 32'h600DF00D);

        // cancel together with start in IDLE drops the request.
        start = 1'b1; cancel = 1'b1; mdOp = 3'd4; din1 = 32'h55555555;
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        checkOutput("cancelIdle.done", W'(done), '0);
        @(negedge clk);
        checkOutput("cancelIdle.done2", W'(done), '0);
        checkOutput("cancelIdle.hi", doutHi, 32'h0BADCAFE);
        expHi = 32'h0BADCAFE;
        expLo = 32'h600DF00D;

        for (int i = 0; i < 400; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
            if ($urandom_range(0, 7) == 0) b = '0;
            if (op == 3'd0 && $urandom_range(0, 15) == 0) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            r = model(op, a, b, expHi, expLo);
            runAndCheck($sformatf("rand%0d.op%0d", i, op), op, a, b, r);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
